// File: rtl/paint_fb_write_arbiter.sv
// Round-robin, grant-holding arbiter for the shared framebuffer write port.
// Accepted writes are registered onto the memory port one cycle after acceptance.
module paint_fb_write_arbiter #(
   parameter int X_W       = 5,
   parameter int Y_W       = 5,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              req,
   input  logic [2:0]              wr_valid,
   input  logic [3*X_W-1:0]        wr_x,
   input  logic [3*Y_W-1:0]        wr_y,
   input  logic [3*DATA_W-1:0]     wr_data,
   input  logic                    mem_busy,
   output logic [2:0]              gnt,
   output logic [2:0]              wr_ready,
   output logic                    mem_we,
   output logic [Y_W+X_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic                    arb_busy
);

   localparam int CNT_W = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SERVE = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [2:0]       gnt_nxt;
   logic [1:0]       last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       g, sel, c1, c2;
   logic             acc, cnt_last, other_req, exit_grant;
   logic [X_W-1:0]   x_g;
   logic [Y_W-1:0]   y_g;
   logic [DATA_W-1:0] d_g;

   always_comb begin
      case (gnt)
         3'b010:  g = 2'd1;
         3'b100:  g = 2'd2;
         default: g = 2'd0;
      endcase
   end

   // Search order starts just after the most recently served requester.
   always_comb begin
      c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      if (req[c1])
         sel = c1;
      else if (req[c2])
         sel = c2;
      else
         sel = last;
   end

   always_comb begin
      case (g)
         2'd1: begin
            x_g = wr_x[X_W +: X_W];
            y_g = wr_y[Y_W +: Y_W];
            d_g = wr_data[DATA_W +: DATA_W];
         end
         2'd2: begin
            x_g = wr_x[2*X_W +: X_W];
            y_g = wr_y[2*Y_W +: Y_W];
            d_g = wr_data[2*DATA_W +: DATA_W];
         end
         default: begin
            x_g = wr_x[0 +: X_W];
            y_g = wr_y[0 +: Y_W];
            d_g = wr_data[0 +: DATA_W];
         end
      endcase
   end

   // A write is accepted only from the granted requester while it still
   // requests and refresh does not own the memory.
   assign wr_ready   = (state == SERVE) ? (gnt & req & {3{~mem_busy}}) : 3'b000;
   assign acc        = |(wr_ready & wr_valid);
   assign cnt_last   = (cnt == CNT_MAX);
   assign other_req  = |(req & ~gnt);
   assign exit_grant = ~|(req & gnt) | (acc & cnt_last & other_req);
   assign arb_busy   = (state != IDLE);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            gnt_nxt = 3'b000;
            if (|req) begin
               state_nxt = SERVE;
               gnt_nxt   = 3'b001 << sel;
               cnt_nxt   = '0;
            end
         end
         default: begin
            if (exit_grant) begin
               state_nxt = IDLE;
               gnt_nxt   = 3'b000;
               last_nxt  = g;
            end else if (acc) begin
               cnt_nxt = cnt_last ? '0 : cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= 3'b000;
         last      <= 2'd2;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state  <= state_nxt;
         gnt    <= gnt_nxt;
         last   <= last_nxt;
         cnt    <= cnt_nxt;
         mem_we <= acc;
         if (acc) begin
            mem_addr  <= {y_g, x_g};
            mem_wdata <= d_g;
         end
      end
   end

endmodule

// File: tb/tb_paint_fb_write_arbiter.sv
// Bench for paint_fb_write_arbiter: directed vector table, hand-written corner
// sequences and random traffic against an ownership-based reference model.
module tb_paint_fb_write_arbiter;

   localparam int X_W = 5;
   localparam int Y_W = 5;
   localparam int DATA_W = 8;
   localparam int MB = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [2:0]           req = '0;
   logic [2:0]           wr_valid = '0;
   logic [3*X_W-1:0]     wr_x = '0;
   logic [3*Y_W-1:0]     wr_y = '0;
   logic [3*DATA_W-1:0]  wr_data = '0;
   logic                 mem_busy = 1'b0;
   logic [2:0]           gnt;
   logic [2:0]           wr_ready;
   logic                 mem_we;
   logic [Y_W+X_W-1:0]   mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 arb_busy;

   always #5 clk = ~clk;

   paint_fb_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .mem_busy(mem_busy), .gnt(gnt), .wr_ready(wr_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .arb_busy(arb_busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who owns the port, who was served last, and how many
   // writes the current owner has had accepted in this grant.
   int                 m_owner, m_last, m_n;
   logic               m_we;
   logic [Y_W+X_W-1:0] m_addr;
   logic [DATA_W-1:0]  m_data;
   logic [2:0]         m_acc_vec;
   logic [2:0]         last_rdy;

   logic [X_W-1:0]    px[3];
   logic [Y_W-1:0]    py[3];
   logic [DATA_W-1:0] pd[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last = 2;
      m_n = 0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_acc_vec = '0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".gnt"}, 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk({tag, ".arb_busy"}, 32'(arb_busy), 32'(m_owner >= 0));
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(m_we));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_addr));
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(m_data));
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic step(input logic [2:0] r, input logic [2:0] v, input logic b, input string tag);
      logic [2:0]         exp_rdy;
      logic               acc;
      int                 n_owner, n_last, n_n;
      logic [Y_W+X_W-1:0] n_addr;
      logic [DATA_W-1:0]  n_data;
      req = r;
      wr_valid = v;
      mem_busy = b;
      for (int i = 0; i < 3; i++) begin
         wr_x[i*X_W +: X_W] = px[i];
         wr_y[i*Y_W +: Y_W] = py[i];
         wr_data[i*DATA_W +: DATA_W] = pd[i];
      end
      #1;
      exp_rdy = '0;
      if (m_owner >= 0 && r[m_owner] && !b) exp_rdy[m_owner] = 1'b1;
      last_rdy = wr_ready;
      chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(exp_rdy));
      acc = (m_owner >= 0) && exp_rdy[m_owner] && v[m_owner];
      m_acc_vec = '0;
      n_owner = m_owner;
      n_last = m_last;
      n_n = m_n;
      n_addr = m_addr;
      n_data = m_data;
      if (m_owner < 0) begin
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (n_owner < 0 && r[c]) begin
               n_owner = c;
               n_n = 0;
            end
         end
      end else begin
         if (acc) begin
            m_acc_vec[m_owner] = 1'b1;
            n_addr = {py[m_owner], px[m_owner]};
            n_data = pd[m_owner];
            n_n = m_n + 1;
         end
         if (!r[m_owner] || (acc && (n_n % MB == 0) && ((r & ~(3'b001 << m_owner)) != 3'b000))) begin
            n_last = m_owner;
            n_owner = -1;
         end
      end
      @(posedge clk);
      #1;
      m_owner = n_owner;
      m_last = n_last;
      m_n = n_n;
      m_we = acc;
      m_addr = n_addr;
      m_data = n_data;
      check_regs(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      wr_valid = '0;
      mem_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_regs("reset");
   endtask

   typedef struct {
      logic [2:0]         req;
      logic [2:0]         vld;
      logic [X_W-1:0]     x;
      logic [2:0]         gnt;
      logic [2:0]         rdy;
      logic               we;
      logic [Y_W+X_W-1:0] addr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got no summary expected summary");
      $fatal(1);
   end

   initial begin
      logic [2:0] got_q[$];
      logic [2:0] exp_q[$];
      logic [2:0] prev_gnt;
      logic [2:0] r, v;
      int done[3];
      int zero_run, we_cnt, acc_cnt, held_cnt;
      bit drop;

      tbl[0] = '{3'b010, 3'b000, 5'd3, 3'b010, 3'b000, 1'b0, 10'd0};
      tbl[1] = '{3'b010, 3'b010, 5'd3, 3'b010, 3'b010, 1'b1, {5'd7, 5'd3}};
      tbl[2] = '{3'b010, 3'b010, 5'd4, 3'b010, 3'b010, 1'b1, {5'd7, 5'd4}};
      tbl[3] = '{3'b010, 3'b010, 5'd5, 3'b010, 3'b010, 1'b1, {5'd7, 5'd5}};
      tbl[4] = '{3'b010, 3'b010, 5'd6, 3'b010, 3'b010, 1'b1, {5'd7, 5'd6}};
      tbl[5] = '{3'b000, 3'b000, 5'd6, 3'b000, 3'b000, 1'b0, {5'd7, 5'd6}};
      tbl[6] = '{3'b000, 3'b000, 5'd6, 3'b000, 3'b000, 1'b0, {5'd7, 5'd6}};

      for (int i = 0; i < 3; i++) begin
         px[i] = '0;
         py[i] = '0;
         pd[i] = '0;
      end

      // Single brush requester, four writes along row 7.
      do_reset();
      py[1] = 5'd7;
      pd[1] = 8'hFF;
      for (int i = 0; i < 7; i++) begin
         px[1] = tbl[i].x;
         step(tbl[i].req, tbl[i].vld, 1'b0, "tbl");
         chk("tbl.rdy", 32'(last_rdy), 32'(tbl[i].rdy));
         chk("tbl.gnt", 32'(gnt), 32'(tbl[i].gnt));
         chk("tbl.we", 32'(mem_we), 32'(tbl[i].we));
         chk("tbl.addr", 32'(mem_addr), 32'(tbl[i].addr));
         if (tbl[i].we) chk("tbl.data", 32'(mem_wdata), 32'hFF);
      end

      // Round-robin: everyone requests, each leaves after two writes.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         px[i] = 5'(i + 1);
         py[i] = 5'(i + 10);
         pd[i] = 8'(8'h30 + i);
         done[i] = 0;
      end
      exp_q = '{3'b001, 3'b010, 3'b100};
      prev_gnt = '0;
      zero_run = 0;
      for (int cy = 0; cy < 20; cy++) begin
         for (int i = 0; i < 3; i++) r[i] = (done[i] < 2);
         step(r, r, 1'b0, "rr");
         for (int i = 0; i < 3; i++) if (m_acc_vec[i]) done[i]++;
         if (gnt != 3'b000 && prev_gnt == 3'b000) begin
            if (got_q.size() > 0) chk("rr.gap", 32'(zero_run), 32'd1);
            got_q.push_back(gnt);
         end
         zero_run = (gnt == 3'b000) ? zero_run + 1 : 0;
         prev_gnt = gnt;
      end
      chk("rr.count", 32'(got_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) chk("rr.order", 32'(got_q[i]), 32'(exp_q[i]));
      step(3'b111, 3'b000, 1'b0, "rr_last");
      chk("rr.last", 32'(gnt), 32'b001);
      step(3'b000, 3'b000, 1'b0, "rr_end");

      // Burst limit with the brush waiting.
      do_reset();
      px[0] = '0;
      py[0] = 5'd2;
      pd[0] = 8'h11;
      for (int cy = 0; cy < 5; cy++) begin
         step(3'b011, 3'b001, 1'b0, "burst");
         if (m_acc_vec[0]) px[0] = px[0] + 5'd1;
      end
      chk("burst.gap", 32'(gnt), 32'b000);
      step(3'b011, 3'b001, 1'b0, "burst");
      chk("burst.next", 32'(gnt), 32'b010);
      step(3'b000, 3'b000, 1'b0, "burst_end");
      step(3'b000, 3'b000, 1'b0, "burst_end");

      // Burst limit with no contention: grant is kept across wraps.
      do_reset();
      px[0] = '0;
      acc_cnt = 0;
      we_cnt = 0;
      drop = 1'b0;
      for (int cy = 0; cy < 13; cy++) begin
         step(3'b001, (acc_cnt < 10) ? 3'b001 : 3'b000, 1'b0, "solo");
         if (m_acc_vec[0]) begin
            acc_cnt++;
            px[0] = px[0] + 5'd1;
         end
         if (mem_we) we_cnt++;
         if (gnt != 3'b001) drop = 1'b1;
      end
      chk("solo.hold", 32'(drop), 32'd0);
      chk("solo.writes", 32'(we_cnt), 32'd10);
      step(3'b000, 3'b000, 1'b0, "solo_end");

      // Refresh stall in mid-burst with the write held.
      do_reset();
      px[0] = 5'd10;
      py[0] = 5'd20;
      pd[0] = 8'hAA;
      acc_cnt = 0;
      held_cnt = 0;
      for (int cy = 0; cy < 9; cy++) begin
         step(3'b001, (acc_cnt < 2) ? 3'b001 : 3'b000, (cy >= 2 && cy <= 4), "stall");
         if (cy >= 2 && cy <= 4) begin
            chk("stall.rdy", 32'(last_rdy), 32'd0);
            chk("stall.we", 32'(mem_we), 32'd0);
         end
         if (m_acc_vec[0]) begin
            acc_cnt++;
            px[0] = 5'd11;
            pd[0] = 8'hBB;
         end
         if (mem_we && mem_addr == {5'd20, 5'd11}) held_cnt++;
      end
      chk("stall.held_once", 32'(held_cnt), 32'd1);
      step(3'b000, 3'b000, 1'b0, "stall_end");

      // Asynchronous reset while a write is on the port.
      do_reset();
      px[0] = 5'd5;
      py[0] = 5'd5;
      pd[0] = 8'h55;
      step(3'b001, 3'b000, 1'b0, "arst");
      step(3'b001, 3'b001, 1'b0, "arst");
      chk("arst.we_before", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst.we", 32'(mem_we), 32'd0);
      chk("arst.gnt", 32'(gnt), 32'd0);
      chk("arst.busy", 32'(arb_busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(3'b111, 3'b000, 1'b0, "arst_after");
      chk("arst.first", 32'(gnt), 32'b001);
      step(3'b000, 3'b000, 1'b0, "arst_end");

      // Random traffic against the model.
      do_reset();
      r = '0;
      for (int cy = 0; cy < 400; cy++) begin
         for (int i = 0; i < 3; i++) begin
            if (r[i]) r[i] = ($urandom_range(0, 7) != 0);
            else      r[i] = ($urandom_range(0, 3) == 0);
            v[i] = $urandom_range(0, 1);
         end
         step(r, v, ($urandom_range(0, 4) == 0), "rand");
         for (int i = 0; i < 3; i++) begin
            if (m_acc_vec[i]) begin
               px[i] = 5'($urandom);
               py[i] = 5'($urandom);
               pd[i] = 8'($urandom);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
